// File: rtl/dct_ctrl_pkg.sv
// Shared constants and FSM state encoding for the 8x8 DCT block scheduler.
package dct_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int WORDS  = 64;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;
endpackage

// File: rtl/dct_blk_buf.sv
// One 8x8 block of sample words: indexed or full-vector write, packed and indexed read.
// Writes land on the next rising edge; reads are combinational, no backpressure.
module dct_blk_buf #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 64,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [IDX_W-1:0]         widx,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     load,
  input  logic [DATA_W*WORDS-1:0]  load_vec,
  input  logic [IDX_W-1:0]         ridx,
  output logic [DATA_W-1:0]        rdata,
  output logic [DATA_W*WORDS-1:0]  vec
);
  logic [WORDS-1:0][DATA_W-1:0] mem;

  // Full-vector load has priority; the two write modes are never used together.
  always_ff @(posedge clk) begin
    if (load) begin
      mem <= load_vec;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign vec   = mem;
  assign rdata = mem[ridx];
endmodule

// File: rtl/dct2d_block_sched.sv
// Collects 64 words, hands the block to the external 2-D DCT core, streams the result out.
// Output one cycle after the core strobe; out_ready stalls hold out_data/out_last steady.
module dct2d_block_sched
  import dct_ctrl_pkg::*;
#(
  parameter int DATA_W  = dct_ctrl_pkg::DATA_W,
  parameter int WORDS   = dct_ctrl_pkg::WORDS,
  parameter int TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic                     dct_start,
  output logic [DATA_W*WORDS-1:0]  dct_x,
  input  logic                     dct_valid_out,
  input  logic [DATA_W*WORDS-1:0]  dct_y,
  output logic                     busy,
  output logic                     err_timeout,
  output logic [15:0]              blk_cnt
);
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   wr_idx, rd_idx;
  logic [CNT_W-1:0]   wait_cnt;
  logic               in_fire, out_fire, capture, timeout_hit;
  logic [DATA_W-1:0]  in_rd_unused;
  logic [DATA_W*WORDS-1:0] out_vec_unused;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign busy     = (state != ST_FILL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_FILL;
      wr_idx      <= '0;
      rd_idx      <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      blk_cnt     <= 16'd0;
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
      end
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
      if (out_fire) begin
        rd_idx <= out_last ? '0 : rd_idx + 1'b1;
        if (out_last) begin
          blk_cnt <= blk_cnt + 16'd1;
        end
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    dct_start   = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_FILL: begin
        in_ready = rst_n;
        if (in_valid && rst_n && (wr_idx == LAST_IDX)) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        dct_start = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A strobe in the last allowed cycle still wins over the timeout.
        if (dct_valid_out) begin
          capture   = 1'b1;
          state_nxt = ST_DRAIN;
        end else if (wait_cnt == CNT_LIM) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_FILL;
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (rd_idx == LAST_IDX);
        if (out_ready && out_last) begin
          state_nxt = ST_FILL;
        end
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  dct_blk_buf #(.DATA_W(DATA_W), .WORDS(WORDS)) u_in_buf (
    .clk      (clk),
    .we       (in_fire),
    .widx     (wr_idx),
    .wdata    (in_data),
    .load     (1'b0),
    .load_vec ('0),
    .ridx     (wr_idx),
    .rdata    (in_rd_unused),
    .vec      (dct_x)
  );

  dct_blk_buf #(.DATA_W(DATA_W), .WORDS(WORDS)) u_out_buf (
    .clk      (clk),
    .we       (1'b0),
    .widx     ('0),
    .wdata    ('0),
    .load     (capture),
    .load_vec (dct_y),
    .ridx     (rd_idx),
    .rdata    (out_data),
    .vec      (out_vec_unused)
  );
endmodule
